// File: rtl/tetris_pkg.sv
// Shared definitions for the Tetris game blocks: controller state encodings,
// board geometry constants and the line-clear score table.
package tetris_pkg;

  localparam int ROWS    = 20;
  localparam int COLS    = 10;
  localparam int CELL_W  = 3;
  localparam int ROW_W   = 5;
  localparam int SCORE_W = 11;
  localparam int TOTAL_W = 16;

  typedef enum logic [2:0] {
    ST_START       = 3'd0,
    ST_PLAY        = 3'd1,
    ST_CHECK_LINES = 3'd2,
    ST_SPAWN       = 3'd3,
    ST_GAME_OVER   = 3'd4
  } game_state_e;

  typedef enum logic [2:0] {
    LC_IDLE = 3'd0,
    LC_READ = 3'd1,
    LC_EVAL = 3'd2,
    LC_FILL = 3'd3,
    LC_DONE = 3'd4
  } line_clear_state_e;

  function automatic logic [SCORE_W-1:0] score_for_lines(input int unsigned n);
    logic [SCORE_W-1:0] s;
    case (n)
      32'd0:   s = 11'd0;
      32'd1:   s = 11'd40;
      32'd2:   s = 11'd100;
      32'd3:   s = 11'd300;
      default: s = 11'd1200;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/tetris_row_full_detect.sv
// Combinational full-row detector: a row is full when every cell is nonzero.
module tetris_row_full_detect #(
  parameter int COLS   = tetris_pkg::COLS,
  parameter int CELL_W = tetris_pkg::CELL_W
) (
  input  logic [COLS*CELL_W-1:0] row,
  output logic                   full
);

  // AND-reduce the per-cell occupancy flags
  always_comb begin
    full = 1'b1;
    for (int c = 0; c < COLS; c++) begin
      full = full & (|row[c*CELL_W +: CELL_W]);
    end
  end

endmodule

// File: rtl/tetris_line_clear.sv
// Scans the board bottom-up, compacts out full rows, zero-fills the top and
// reports the cleared-line count, score increment and running line total.
module tetris_line_clear #(
  parameter int ROWS   = tetris_pkg::ROWS,
  parameter int COLS   = tetris_pkg::COLS,
  parameter int CELL_W = tetris_pkg::CELL_W,
  parameter int ROW_W  = tetris_pkg::ROW_W
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic [2:0]             state_in,
  output logic [ROW_W-1:0]       rd_addr,
  input  logic [COLS*CELL_W-1:0] rd_data,
  output logic                   wr_en,
  output logic [ROW_W-1:0]       wr_addr,
  output logic [COLS*CELL_W-1:0] wr_data,
  output logic                   line_scan_done,
  output logic [ROW_W-1:0]       lines_cleared,
  output logic [10:0]            score_add,
  output logic [15:0]            total_lines
);
  import tetris_pkg::*;

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  line_clear_state_e state_r, state_s;
  logic [ROW_W-1:0]  r_r, w_r, cnt_r, cnt_nxt_s;
  logic              fill_pending_r;
  logic [ROW_W-1:0]  lines_r;
  logic [10:0]       score_r;
  logic [15:0]       total_r;
  logic [16:0]       total_sum_s;
  logic              done_r;
  logic              row_full_s;
  logic              wr_en_s;
  logic [ROW_W-1:0]  wr_addr_s;
  logic [COLS*CELL_W-1:0] wr_data_s;

  tetris_row_full_detect #(.COLS(COLS), .CELL_W(CELL_W)) u_row_full (
    .row  (rd_data),
    .full (row_full_s)
  );

  assign cnt_nxt_s   = cnt_r + ROW_W'(row_full_s);
  assign total_sum_s = {1'b0, total_r} + 17'(cnt_r);

  // State register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r <= LC_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; the row-0 decision uses the count including row 0 itself
  always_comb begin
    state_s = state_r;
    case (state_r)
      LC_IDLE: begin
        if (state_in == ST_CHECK_LINES) state_s = LC_READ;
        else                            state_s = LC_IDLE;
      end
      LC_READ: state_s = LC_EVAL;
      LC_EVAL: begin
        if (r_r == '0) begin
          if (cnt_nxt_s != '0) state_s = LC_FILL;
          else                 state_s = LC_DONE;
        end else begin
          state_s = LC_READ;
        end
      end
      LC_FILL: begin
        if (w_r == '0 || !fill_pending_r) state_s = LC_DONE;
        else                              state_s = LC_FILL;
      end
      LC_DONE: state_s = LC_IDLE;
      default: state_s = LC_IDLE;
    endcase
  end

  // Write-port drive: compaction copies in EVAL, zero rows in FILL
  always_comb begin
    wr_en_s   = 1'b0;
    wr_addr_s = w_r;
    wr_data_s = '0;
    case (state_r)
      LC_EVAL: begin
        if (!row_full_s && (w_r != r_r)) begin
          wr_en_s   = 1'b1;
          wr_data_s = rd_data;
        end else begin
          wr_en_s   = 1'b0;
        end
      end
      LC_FILL: wr_en_s = 1'b1;
      default: wr_en_s = 1'b0;
    endcase
  end

  // Scan pointers, counters and result registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_r            <= '0;
      w_r            <= '0;
      cnt_r          <= '0;
      fill_pending_r <= 1'b0;
      lines_r        <= '0;
      score_r        <= '0;
      done_r         <= 1'b0;
    end else begin
      done_r <= (state_s == LC_DONE);
      case (state_r)
        LC_IDLE: begin
          if (state_in == ST_CHECK_LINES) begin
            r_r     <= LAST_ROW;
            w_r     <= LAST_ROW;
            cnt_r   <= '0;
            lines_r <= '0;
            score_r <= '0;
          end
        end
        LC_EVAL: begin
          cnt_r          <= cnt_nxt_s;
          fill_pending_r <= (r_r == '0) && (cnt_nxt_s != '0);
          if (!row_full_s) w_r <= w_r - ROW_W'(1);
          if (r_r != '0)   r_r <= r_r - ROW_W'(1);
        end
        LC_FILL: begin
          if (w_r != '0) w_r <= w_r - ROW_W'(1);
          else           fill_pending_r <= 1'b0;
        end
        LC_DONE: begin
          lines_r <= cnt_r;
          score_r <= score_for_lines(32'(cnt_r));
        end
        default: ;
      endcase
    end
  end

  // Cumulative total; START wipes it, otherwise it accumulates with saturation
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      total_r <= '0;
    end else if (state_in == ST_START) begin
      total_r <= '0;
    end else if (state_r == LC_DONE) begin
      total_r <= total_sum_s[16] ? 16'hFFFF : total_sum_s[15:0];
    end
  end

  assign rd_addr        = r_r;
  assign wr_en          = wr_en_s;
  assign wr_addr        = wr_addr_s;
  assign wr_data        = wr_data_s;
  assign line_scan_done = done_r;
  assign lines_cleared  = lines_r;
  assign score_add      = score_r;
  assign total_lines    = total_r;

endmodule

// File: tb/tb_tetris_line_clear.sv
// Directed testbench for tetris_line_clear with a synchronous board RAM model.
module tb_tetris_line_clear;
  import tetris_pkg::*;

  localparam int RB = COLS * CELL_W;
  localparam logic [RB-1:0] FULL_ROW = {10{3'b101}};
  localparam logic [RB-1:0] PAT_P    = 30'h0123_4567;
  localparam logic [RB-1:0] PAT_Q    = 30'h0000_0003;
  localparam logic [RB-1:0] PAT_A    = 30'h0000_0A00;
  localparam logic [RB-1:0] PAT_B    = 30'h0006_0000;
  localparam logic [RB-1:0] PAT_C    = 30'h0000_0041;

  logic             Clk = 1'b0;
  logic             Reset_n;
  logic [2:0]       state_in;
  logic [ROW_W-1:0] rd_addr;
  logic [RB-1:0]    rd_data;
  logic             wr_en;
  logic [ROW_W-1:0] wr_addr;
  logic [RB-1:0]    wr_data;
  logic             line_scan_done;
  logic [ROW_W-1:0] lines_cleared;
  logic [10:0]      score_add;
  logic [15:0]      total_lines;

  logic [RB-1:0]    mem [ROWS];
  logic [RB-1:0]    init_row [ROWS];
  logic             load_req;

  logic [ROW_W-1:0] hist_addr [64];
  logic [RB-1:0]    hist_data [64];
  int               wr_count;
  int               lat;
  int               checks = 0;
  int               errors = 0;

  tetris_line_clear dut (
    .Clk(Clk), .Reset_n(Reset_n), .state_in(state_in),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .line_scan_done(line_scan_done), .lines_cleared(lines_cleared),
    .score_add(score_add), .total_lines(total_lines)
  );

  always #5 Clk = ~Clk;

  // Board RAM: synchronous read, one write port, bulk load for test setup
  always @(posedge Clk) begin
    if (load_req) begin
      for (int i = 0; i < ROWS; i++) mem[i] <= init_row[i];
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_init();
    for (int i = 0; i < ROWS; i++) init_row[i] = '0;
  endtask

  task automatic load_board();
    @(negedge Clk);
    load_req = 1'b1;
    @(negedge Clk);
    load_req = 1'b0;
  endtask

  // Start a scan, log writes, measure cycles to the done pulse
  task automatic run_scan(output int latency);
    int  n;
    bit  seen;
    n = 0;
    seen = 1'b0;
    latency = 0;
    wr_count = 0;
    @(negedge Clk);
    state_in = 3'd2;
    @(posedge Clk);
    #1 state_in = 3'd1;
    while (!seen && n < 150) begin
      @(negedge Clk);
      n++;
      if (wr_en) begin
        if (wr_count < 64) begin
          hist_addr[wr_count] = wr_addr;
          hist_data[wr_count] = wr_data;
        end
        wr_count++;
      end
      if (line_scan_done) begin
        latency = n;
        seen = 1'b1;
      end
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Reset_n  = 1'b0;
    state_in = 3'd1;
    load_req = 1'b0;
    clear_init();
    repeat (2) @(negedge Clk);
    check("rst_done", 32'(line_scan_done), 32'd0);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_lines", 32'(lines_cleared), 32'd0);
    check("rst_score", 32'(score_add), 32'd0);
    check("rst_total", 32'(total_lines), 32'd0);
    check("rst_rd_addr", 32'(rd_addr), 32'd0);
    Reset_n = 1'b1;

    // 1: empty board
    clear_init();
    load_board();
    run_scan(lat);
    check("t1_latency", 32'(lat), 32'd41);
    check("t1_writes", 32'(wr_count), 32'd0);
    check("t1_lines", 32'(lines_cleared), 32'd0);
    check("t1_score", 32'(score_add), 32'd0);

    // 2: row 19 full, row 18 = P
    clear_init();
    init_row[19] = FULL_ROW;
    init_row[18] = PAT_P;
    load_board();
    run_scan(lat);
    check("t2_latency", 32'(lat), 32'd42);
    check("t2_writes", 32'(wr_count), 32'd20);
    check("t2_first_addr", 32'(hist_addr[0]), 32'd19);
    check("t2_first_data", 32'(hist_data[0]), 32'(PAT_P));
    check("t2_last_addr", 32'(hist_addr[19]), 32'd0);
    check("t2_last_data", 32'(hist_data[19]), 32'd0);
    check("t2_mem19", 32'(mem[19]), 32'(PAT_P));
    check("t2_mem18", 32'(mem[18]), 32'd0);
    check("t2_lines", 32'(lines_cleared), 32'd1);
    check("t2_score", 32'(score_add), 32'd40);
    check("t2_total", 32'(total_lines), 32'd1);

    // 3: rows 16-19 full, row 15 = Q
    clear_init();
    for (int i = 16; i < 20; i++) init_row[i] = FULL_ROW;
    init_row[15] = PAT_Q;
    load_board();
    run_scan(lat);
    check("t3_latency", 32'(lat), 32'd45);
    check("t3_writes", 32'(wr_count), 32'd20);
    check("t3_fill_first", 32'(hist_addr[16]), 32'd3);
    check("t3_fill_last", 32'(hist_addr[19]), 32'd0);
    check("t3_mem19", 32'(mem[19]), 32'(PAT_Q));
    check("t3_lines", 32'(lines_cleared), 32'd4);
    check("t3_score", 32'(score_add), 32'd1200);
    check("t3_total", 32'(total_lines), 32'd5);

    // 4: non-adjacent full rows 19 and 17
    clear_init();
    init_row[19] = FULL_ROW;
    init_row[18] = PAT_A;
    init_row[17] = FULL_ROW;
    init_row[16] = PAT_B;
    init_row[1]  = PAT_C;
    init_row[0]  = PAT_C;
    load_board();
    run_scan(lat);
    check("t4_latency", 32'(lat), 32'd43);
    check("t4_writes", 32'(wr_count), 32'd20);
    check("t4_fill_a", 32'(hist_addr[18]), 32'd1);
    check("t4_fill_b", 32'(hist_addr[19]), 32'd0);
    check("t4_mem19", 32'(mem[19]), 32'(PAT_A));
    check("t4_mem18", 32'(mem[18]), 32'(PAT_B));
    check("t4_mem3", 32'(mem[3]), 32'(PAT_C));
    check("t4_mem2", 32'(mem[2]), 32'(PAT_C));
    check("t4_mem1", 32'(mem[1]), 32'd0);
    check("t4_mem0", 32'(mem[0]), 32'd0);
    check("t4_score", 32'(score_add), 32'd100);
    check("t4_total", 32'(total_lines), 32'd7);

    // 5: reset mid-scan, then a clean restart
    clear_init();
    init_row[19] = FULL_ROW;
    init_row[18] = PAT_P;
    load_board();
    @(negedge Clk);
    state_in = 3'd2;
    @(posedge Clk);
    #1 state_in = 3'd1;
    repeat (10) @(negedge Clk);
    check("t5_pre_wr_en", 32'(wr_en), 32'd1);
    #2 Reset_n = 1'b0;
    #1;
    check("t5_wr_en", 32'(wr_en), 32'd0);
    check("t5_done", 32'(line_scan_done), 32'd0);
    check("t5_total", 32'(total_lines), 32'd0);
    check("t5_rd_addr", 32'(rd_addr), 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    load_board();
    run_scan(lat);
    check("t5_latency", 32'(lat), 32'd42);
    check("t5_lines", 32'(lines_cleared), 32'd1);
    check("t5_score", 32'(score_add), 32'd40);
    check("t5_total_after", 32'(total_lines), 32'd1);

    // 6: saturation near the top, then START clears the total
    @(negedge Clk);
    force dut.total_r = 16'hFFFE;
    @(negedge Clk);
    release dut.total_r;
    @(negedge Clk);
    check("t6_preset", 32'(total_lines), 32'h0000FFFE);
    clear_init();
    for (int i = 17; i < 20; i++) init_row[i] = FULL_ROW;
    load_board();
    run_scan(lat);
    check("t6_latency", 32'(lat), 32'd44);
    check("t6_lines", 32'(lines_cleared), 32'd3);
    check("t6_score", 32'(score_add), 32'd300);
    check("t6_total_sat", 32'(total_lines), 32'h0000FFFF);
    @(negedge Clk);
    state_in = 3'd0;
    @(posedge Clk);
    #1 state_in = 3'd1;
    check("t6_total_clr", 32'(total_lines), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tetris_line_clear.md
Name: tetris_line_clear

Overview:
- Downstream consumer of the game-state controller. While the controller sits in CHECK_LINES, this block scans the board RAM from the bottom row upward and compacts out every full row.
- Blank rows are refilled at the top.
- When finished, it reports the cleared-line count and score increment, and pulses line_scan_done so the controller advances to SPAWN.
- The board RAM is external, with one synchronous read port and one write port, and is shared with the piece-lock logic.

Parameters:
- ROWS, 20, board height in rows; row 0 is the top.
- COLS, 10, board width in cells.
- CELL_W, 3, bits per cell; 0 means empty, nonzero means a colour index.
- ROW_W, 5, address width, with ROWS <= 2**ROW_W.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- state_in  in  3  controller state (0 START, 1 PLAY, 2 CHECK_LINES, 3 SPAWN, 4 GAME_OVER).
- rd_addr  out  ROW_W  board RAM read address; rd_data is valid 1 cycle later.
- rd_data  in  COLS*CELL_W  row read from the RAM; cell c occupies bits [c*CELL_W +: CELL_W].
- wr_en  out  1  board RAM write strobe.
- wr_addr  out  ROW_W  write row address.
- wr_data  out  COLS*CELL_W  row data to write.
- line_scan_done  out  1  one-cycle pulse when the scan and refill are complete.
- lines_cleared  out  ROW_W  number of full rows removed in the last scan; held until the next scan starts.
- score_add  out  11  points for the last scan; held with lines_cleared.
- total_lines  out  16  cumulative cleared lines.

Behaviour:
- Reset (async, Reset_n=0): FSM goes to IDLE. All outputs are 0, and wr_en drops immediately, without waiting for a clock edge.
- States: IDLE, READ, EVAL, FILL, DONE.
- Internal registers: r (read row), w (write row), cnt (full rows seen), fill_pending flag.
- IDLE: when state_in==2, set r=w=ROWS-1 and cnt=0, clear lines_cleared and score_add, then go to READ.
- READ: drive rd_addr=r, then go to EVAL.
- EVAL: rd_data holds row r. A row is full when every one of its COLS cells is nonzero.
  - Row full: cnt+1, no write.
  - Row not full: if w!=r, write rd_data to row w (wr_en=1 for this cycle). Decrement w in either case.
  - Then, if r==0: go to FILL when cnt>0, otherwise go to DONE. Else decrement r and go to READ.
- FILL: write all-zero data to row w, once per cycle.
  - If w==0, go to DONE; otherwise decrement w.
  - Exactly cnt rows are zeroed, namely rows cnt-1 down to 0.
- DONE: update the output registers, assert line_scan_done for exactly one cycle, then go to IDLE.
  - lines_cleared=cnt.
  - score_add per the table: 0→0, 1→40, 2→100, 3→300, >=4→1200.
  - total_lines += cnt, saturating at 16'hFFFF.
- Handshake with the controller:
  - The controller samples line_scan_done on the same edge where this block returns to IDLE, so state_in reads 3 on the next cycle and no re-trigger occurs.
  - state_in values other than 2 are ignored outside IDLE. A started scan always completes unless Reset_n is asserted.
- Latency: 2*ROWS + cnt + 1 cycles from leaving IDLE to line_scan_done. With ROWS=20 and cnt=0, that is 41 cycles.
- total_lines clears to 0 synchronously whenever state_in==0 (START). It is otherwise retained across scans.
- wr_en is asserted only in EVAL (compaction writes) and in FILL. It is never asserted in the same cycle as a read that targets the same row.
- Reads always lead writes: w >= r at all times, so a row is always read before it is overwritten.
- Board entirely full (cnt=ROWS): no EVAL writes, FILL zeros all ROWS rows, lines_cleared=ROWS, score_add=1200.
- Reset mid-scan: the RAM contents are left partially compacted. The controller also returns to START on reset, so no recovery is required.

Decomposition:
- tetris_pkg holds:
  - The controller state encodings as a shared typedef (START..GAME_OVER), used by both the controller and this block.
  - The ROWS/COLS/CELL_W constants.
  - A score_for_lines function implementing the score table.
- One combinational sub-module, tetris_row_full_detect: a COLS*CELL_W row in, a 1-bit full flag out. It is reused by any future row-preview logic.

Test Plan:
1. Empty board, state_in=2: line_scan_done arrives 41 cycles after the start, wr_en is never high, lines_cleared=0, score_add=0.
2. Row 19 full, row 18 holding pattern P:
   - Required writes: row 19←P, then row 18 onward shifts down, then row 0←0.
   - lines_cleared=1, score_add=40, and the done pulse arrives at cycle 42.
3. Rows 16-19 full, row 15 holding Q: Q moves to row 19, rows 3-0 are zeroed, lines_cleared=4, score_add=1200, total_lines increases by 4.
4. Non-adjacent full rows 19 and 17: the remaining rows compact in order, with exactly 2 zero-fill writes to rows 1 and 0, and score_add=100.
5. Reset_n pulsed low at cycle 10 of a scan: wr_en=0 and all outputs are 0 immediately; the next state_in=2 restarts the scan cleanly.
6. total_lines preset near 16'hFFFE, then a 3-line clear: total_lines=16'hFFFF. A following cycle with state_in=0 clears it to 0.
